mux_pipe_rr: RTL and testbench
==============================

MUX_PIPE_RR -- requirements
Module: mux_pipe_rr

Interface
REQ-001 Parameter: WIDTH, 144, payload width in bits.
REQ-002 Parameter: NCHAN, 4, input channel count, 2..16.
REQ-003 Parameter: DEPTH, 2, per-channel FIFO entries, power of 2, >= 2.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 nRST  input  1  reset, asynchronous assert, active-low.
REQ-006 in$enq__ENA  input  NCHAN  per-channel enqueue strobe.
REQ-007 in$enq$v  input  NCHAN*WIDTH  per-channel payload; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in$enq__RDY  output  NCHAN  per-channel ready; equals FIFO i not full.
REQ-009 out$enq__ENA  output  1  output transfer strobe.
REQ-010 out$enq$v  output  WIDTH  output payload; zero when out$enq__ENA is 0.
REQ-011 out$enq__RDY  input  1  downstream ready.
REQ-012 out$chan  output  clog2(NCHAN)  source channel of current transfer; zero when out$enq__ENA is 0.

Function
REQ-013 Each channel SHALL own a DEPTH-entry FIFO with write pointer, read pointer and occupancy count of width clog2(DEPTH+1); pointers wrap modulo DEPTH.
REQ-014 An enqueue on channel i SHALL occur when in$enq__ENA[i] and in$enq__RDY[i] are both 1; ENA while RDY is 0 SHALL be ignored, with no state change.
REQ-015 in$enq__RDY[i] SHALL depend only on registered occupancy, never combinationally on any ENA or on out$enq__RDY.
REQ-016 No bypass: data enqueued in cycle N SHALL be eligible for output no earlier than cycle N+1.
REQ-017 out$enq__ENA SHALL be 1 exactly when out$enq__RDY is 1 and at least one FIFO is non-empty; a dequeue of the granted FIFO occurs in the same cycle.
REQ-018 The arbiter SHALL use round-robin: grant the lowest-index non-empty channel at or above pointer rr, wrapping modulo NCHAN.
REQ-019 After each transfer, rr SHALL become (granted index + 1) mod NCHAN; without a transfer, rr SHALL hold.
REQ-020 Simultaneous enqueue and dequeue on the same non-full FIFO SHALL leave occupancy unchanged and preserve FIFO order.
REQ-021 A FIFO that is full at the start of a cycle SHALL NOT accept an enqueue in that cycle, even when it is dequeued in that cycle; RDY rises the following cycle.
REQ-022 A single channel with continuous input and out$enq__RDY held 1 SHALL sustain one transfer per cycle.

Reset
REQ-023 While nRST is 0: all FIFOs empty, rr = 0, in$enq__RDY = 0, out$enq__ENA = 0, out$enq$v = 0, out$chan = 0.
REQ-024 Assertion of nRST mid-operation SHALL discard all queued data immediately, without waiting for a clock edge.
REQ-025 On the first cycle after nRST deasserts, in$enq__RDY SHALL be all ones.

Configuration
REQ-026 Macro MUX_PIPE_RR_STRICT_PRIO_EN.
  - Defined: arbitration is fixed priority, lowest non-empty index wins, and rr is not implemented.
  - Undefined: round-robin per REQ-018/019.
  - All other behaviour is identical in both builds.

Verification (NCHAN=4, DEPTH=2, WIDTH=144)
REQ-027 Single channel: enqueue 0x11 on ch2 with out RDY=1 -> next cycle out ENA=1, v=0x11, chan=2; following cycle ENA=0.
REQ-028 Round-robin order: two entries per channel loaded with out RDY=0, then RDY=1 -> chan sequence 0,1,2,3,0,1,2,3 on 8 consecutive cycles, then ENA=0.
REQ-029 Full channel: two enqueues on ch1 with out RDY=0 -> in RDY[1]=0; raise out RDY -> ch1 data dequeued that cycle and in RDY[1]=1 the next cycle.
REQ-030 Strict priority (macro defined): ch0 and ch3 fed every cycle, out RDY=1 -> only chan=0 transfers; stop ch0 -> ch3 is served after ch0 drains.
REQ-031 Reset mid-stream: all FIFOs full, pull nRST low between edges -> out ENA=0 and in RDY=0 immediately; after release, in RDY=4'b1111 and no stale output.
REQ-032 Throughput: ch0 enqueue every cycle for 20 cycles with out RDY=1 -> 20 consecutive transfers in order, occupancy never exceeds 1.

Source files
------------

// File: rtl/mux_pipe_rr.sv
// N-channel FIFO mux: one DEPTH-entry FIFO per input, round-robin arbitration onto a single output.
// Define MUX_PIPE_RR_STRICT_PRIO_EN for fixed lowest-index-first priority instead of round-robin.
module mux_pipe_rr #(
    parameter int WIDTH  = 144,
    parameter int NCHAN  = 4,
    parameter int DEPTH  = 2,
    localparam int CHAN_W = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NCHAN-1:0]        in_enq__ENA,
    input  logic [NCHAN*WIDTH-1:0]  in_enq_v,
    output logic [NCHAN-1:0]        in_enq__RDY,
    output logic                    out_enq__ENA,
    output logic [WIDTH-1:0]        out_enq_v,
    input  logic                    out_enq__RDY,
    output logic [CHAN_W-1:0]       out_chan
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  mem    [NCHAN][DEPTH];
    logic [PTR_W-1:0]  wr_ptr [NCHAN];
    logic [PTR_W-1:0]  rd_ptr [NCHAN];
    logic [CNT_W-1:0]  cnt    [NCHAN];

    logic [NCHAN-1:0]  nonempty;
    logic [NCHAN-1:0]  enq;
    logic [NCHAN-1:0]  deq;
    logic              grant_vld;
    logic [CHAN_W-1:0] grant;

`ifdef MUX_PIPE_RR_STRICT_PRIO_EN
`else
    logic [CHAN_W-1:0] rr;
`endif

    // Ready is derived only from registered occupancy; forced low while reset is held.
    always_comb begin
        for (int i = 0; i < NCHAN; i++) begin
            nonempty[i]    = (cnt[i] != '0);
            in_enq__RDY[i] = nRST && (cnt[i] != CNT_W'(DEPTH));
        end
    end

    assign enq = in_enq__ENA & in_enq__RDY;

    always_comb begin
        int c;
        grant_vld = 1'b0;
        grant     = '0;
        c         = 0;
        for (int k = 0; k < NCHAN; k++) begin
`ifdef MUX_PIPE_RR_STRICT_PRIO_EN
            c = k;
`else
            c = (int'(rr) + k) % NCHAN;
`endif
            if (!grant_vld && nonempty[c]) begin
                grant_vld = 1'b1;
                grant     = CHAN_W'(c);
            end
        end
    end

    assign out_enq__ENA = out_enq__RDY && grant_vld;
    assign deq          = out_enq__ENA ? (NCHAN'(1) << grant) : '0;
    assign out_enq_v    = out_enq__ENA ? mem[grant][rd_ptr[grant]] : '0;
    assign out_chan     = out_enq__ENA ? grant : '0;

    // Payload storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NCHAN; i++) begin
            if (enq[i]) begin
                mem[i][wr_ptr[i]] <= in_enq_v[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NCHAN; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (enq[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
                end
                if (deq[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
                end
                if (enq[i] && !deq[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end else if (!enq[i] && deq[i]) begin
                    cnt[i] <= cnt[i] - CNT_W'(1);
                end
            end
        end
    end

`ifdef MUX_PIPE_RR_STRICT_PRIO_EN
`else
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rr <= '0;
        end else if (out_enq__ENA) begin
            rr <= CHAN_W'((int'(grant) + 1) % NCHAN);
        end
    end
`endif

endmodule

// File: tb/tb_mux_pipe_rr.sv
// Randomized and directed bench for mux_pipe_rr against a queue-based reference model.
module tb_mux_pipe_rr;

    localparam int WIDTH = 144;
    localparam int NCHAN = 4;
    localparam int DEPTH = 2;
    localparam int CW    = 2;

    logic                   CLK = 1'b0;
    logic                   nRST;
    logic [NCHAN-1:0]       in_ena;
    logic [NCHAN*WIDTH-1:0] in_v;
    logic [NCHAN-1:0]       in_rdy;
    logic                   out_ena;
    logic [WIDTH-1:0]       out_v;
    logic                   out_rdy;
    logic [CW-1:0]          out_chan;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] q [NCHAN][$];
    int rr = 0;

    logic [NCHAN-1:0] obs_rdy;
    logic             obs_ena;
    logic [CW-1:0]    obs_chan;

    mux_pipe_rr #(.WIDTH(WIDTH), .NCHAN(NCHAN), .DEPTH(DEPTH)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .in_enq__ENA (in_ena),
        .in_enq_v    (in_v),
        .in_enq__RDY (in_rdy),
        .out_enq__ENA(out_ena),
        .out_enq_v   (out_v),
        .out_enq__RDY(out_rdy),
        .out_chan    (out_chan)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[WIDTH-1:0];
    endfunction

    // Reference arbiter: first non-empty queue scanning from the fairness pointer.
    function automatic int pick();
        int c;
        for (int k = 0; k < NCHAN; k++) begin
`ifdef MUX_PIPE_RR_STRICT_PRIO_EN
            c = k;
`else
            c = (rr + k) % NCHAN;
`endif
            if (q[c].size() > 0) return c;
        end
        return -1;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NCHAN; i++) q[i].delete();
        rr = 0;
    endfunction

    // Entered just after a falling edge; leaves just after the next falling edge.
    task automatic cycle(input logic [NCHAN-1:0] ena, input logic [NCHAN*WIDTH-1:0] v, input logic ordy);
        int g;
        logic [NCHAN-1:0] erdy;
        logic             eena;
        logic [WIDTH-1:0] ev;
        logic [CW-1:0]    ec;
        in_ena  = ena;
        in_v    = v;
        out_rdy = ordy;
        #1;
        g = pick();
        for (int i = 0; i < NCHAN; i++) erdy[i] = (q[i].size() < DEPTH);
        eena = ordy && (g >= 0);
        ev   = '0;
        ec   = '0;
        if (eena) begin
            ev = q[g][0];
            ec = CW'(g);
        end
        obs_rdy  = in_rdy;
        obs_ena  = out_ena;
        obs_chan = out_chan;
        chk("in_rdy",   WIDTH'(in_rdy),   WIDTH'(erdy));
        chk("out_ena",  WIDTH'(out_ena),  WIDTH'(eena));
        chk("out_v",    out_v,            ev);
        chk("out_chan", WIDTH'(out_chan), WIDTH'(ec));
        @(posedge CLK);
        for (int i = 0; i < NCHAN; i++)
            if (ena[i] && erdy[i]) q[i].push_back(v[i*WIDTH +: WIDTH]);
        if (eena) begin
            void'(q[g].pop_front());
            rr = (g + 1) % NCHAN;
        end
        @(negedge CLK);
    endtask

    function automatic logic [NCHAN*WIDTH-1:0] rand_bus();
        logic [NCHAN*WIDTH-1:0] b;
        for (int i = 0; i < NCHAN; i++) b[i*WIDTH +: WIDTH] = rand_word();
        return b;
    endfunction

    task automatic fill_all();
        cycle(4'b1111, rand_bus(), 1'b0);
        cycle(4'b1111, rand_bus(), 1'b0);
    endtask

    task automatic mid_reset();
        #2;
        out_rdy = 1'b1;
        in_ena  = 4'b1111;
        nRST    = 1'b0;
        #1;
        chk("rst_in_rdy",  WIDTH'(in_rdy),  WIDTH'(4'b0000));
        chk("rst_out_ena", WIDTH'(out_ena), WIDTH'(1'b0));
        chk("rst_out_v",   out_v,           '0);
        chk("rst_chan",    WIDTH'(out_chan), '0);
        model_clear();
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        cycle(4'b0000, rand_bus(), 1'b1);
        chk("post_rst_rdy", WIDTH'(obs_rdy), WIDTH'(4'b1111));
        chk("post_rst_ena", WIDTH'(obs_ena), WIDTH'(1'b0));
    endtask

    initial begin
        logic [NCHAN*WIDTH-1:0] b;
        nRST    = 1'b0;
        in_ena  = 4'b1111;
        in_v    = '0;
        out_rdy = 1'b1;
        #1;
        chk("reset_in_rdy",  WIDTH'(in_rdy),   WIDTH'(4'b0000));
        chk("reset_out_ena", WIDTH'(out_ena),  WIDTH'(1'b0));
        chk("reset_out_v",   out_v,            '0);
        chk("reset_chan",    WIDTH'(out_chan), '0);
        model_clear();
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        // Round-robin order over two full rounds.
        fill_all();
        for (int k = 0; k < 2 * NCHAN; k++) begin
            cycle(4'b0000, '0, 1'b1);
            chk("rr_ena", WIDTH'(obs_ena), WIDTH'(1'b1));
`ifdef MUX_PIPE_RR_STRICT_PRIO_EN
            chk("prio_chan", WIDTH'(obs_chan), WIDTH'(k / 2));
`else
            chk("rr_chan", WIDTH'(obs_chan), WIDTH'(k % NCHAN));
`endif
        end
        cycle(4'b0000, '0, 1'b1);
        chk("rr_drained", WIDTH'(obs_ena), WIDTH'(1'b0));

        // Single transfer with a one-cycle enqueue-to-output latency.
        b = '0;
        b[2*WIDTH +: WIDTH] = WIDTH'(8'h11);
        cycle(4'b0100, b, 1'b1);
        chk("single_no_bypass", WIDTH'(obs_ena), WIDTH'(1'b0));
        cycle(4'b0000, '0, 1'b1);
        chk("single_chan", WIDTH'(obs_chan), WIDTH'(2));
        cycle(4'b0000, '0, 1'b1);
        chk("single_done", WIDTH'(obs_ena), WIDTH'(1'b0));

        // Full channel refuses an enqueue even while it is being drained.
        cycle(4'b0010, rand_bus(), 1'b0);
        cycle(4'b0010, rand_bus(), 1'b0);
        cycle(4'b0010, rand_bus(), 1'b1);
        chk("full_rdy_low", WIDTH'(obs_rdy[1]), WIDTH'(1'b0));
        cycle(4'b0000, '0, 1'b0);
        chk("full_rdy_back", WIDTH'(obs_rdy[1]), WIDTH'(1'b1));
        cycle(4'b0000, '0, 1'b1);
        cycle(4'b0000, '0, 1'b1);

        // Sustained single-channel throughput.
        for (int k = 0; k < 20; k++) begin
            cycle(4'b0001, rand_bus(), 1'b1);
            chk("thru_rdy", WIDTH'(obs_rdy[0]), WIDTH'(1'b1));
            if (k > 0) chk("thru_ena", WIDTH'(obs_ena), WIDTH'(1'b1));
        end
        cycle(4'b0000, '0, 1'b1);
        chk("thru_last", WIDTH'(obs_ena), WIDTH'(1'b1));

        // Two busy channels: fixed priority starves ch3, round-robin alternates.
        for (int k = 0; k < 10; k++) cycle(4'b1001, rand_bus(), 1'b1);
        for (int k = 0; k < 6; k++) cycle(4'b0000, '0, 1'b1);

        fill_all();
        mid_reset();

        for (int k = 0; k < 800; k++) begin
            cycle(NCHAN'($urandom()), rand_bus(), ($urandom_range(0, 3) != 0));
        end
        fill_all();
        mid_reset();
        for (int k = 0; k < 200; k++) begin
            cycle(NCHAN'($urandom()), rand_bus(), ($urandom_range(0, 1) != 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
